// File: rtl/sraml_axi_bridge.sv
// sraml_axi_bridge: arbitrates an instruction-side and a data-side
// sram-like port onto a single AXI master. One transaction is in flight
// at a time; data requests win over instruction requests.
module sraml_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  // instruction side (reads only)
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  state_t      state, state_next;
  logic        owner_data, owner_data_next;   // 1: data side owns the transaction
  logic        wr, wr_next;
  logic [1:0]  size, size_next;
  logic [31:0] addr, addr_next;
  logic [31:0] wdat, wdat_next;
  logic        aw_done, aw_done_next;
  logic        w_done, w_done_next;

  // Side-channel fields that the bridge deliberately does not look at.
  logic unused_ok;
  assign unused_ok = &{1'b0, inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp};

  // Single-beat, incrementing, unlocked, uncached bursts only.
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'b00;
  assign awlock  = 2'b00;
  assign arcache = 4'b0000;
  assign awcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awprot  = 3'b000;
  assign wlast   = 1'b1;
  assign awid    = 4'd1;
  assign wid     = 4'd1;

  // Address/data fields come straight from the latched request.
  assign araddr = addr;
  assign awaddr = addr;
  assign arsize = {1'b0, size};
  assign awsize = {1'b0, size};
  assign arid   = {3'b000, owner_data};
  assign wdata  = wdat;

  // Byte strobes for the latched size and low address bits.
  always_comb begin
    case (size)
      2'd0:    wstrb = 4'b0001 << addr[1:0];
      2'd1:    wstrb = 4'b0011 << {addr[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

  // State and request latches; reset clears everything immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      wr         <= 1'b0;
      size       <= 2'd0;
      addr       <= 32'd0;
      wdat       <= 32'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_next;
      owner_data <= owner_data_next;
      wr         <= wr_next;
      size       <= size_next;
      addr       <= addr_next;
      wdat       <= wdat_next;
      aw_done    <= aw_done_next;
      w_done     <= w_done_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next      = state;
    owner_data_next = owner_data;
    wr_next         = wr;
    size_next       = size;
    addr_next       = addr;
    wdat_next       = wdat;
    aw_done_next    = aw_done;
    w_done_next     = w_done;
    inst_addr_ok    = 1'b0;
    data_addr_ok    = 1'b0;
    inst_data_ok    = 1'b0;
    data_data_ok    = 1'b0;
    inst_rdata      = 32'd0;
    data_rdata      = 32'd0;
    arvalid         = 1'b0;
    rready          = 1'b0;
    awvalid         = 1'b0;
    wvalid          = 1'b0;
    bready          = 1'b0;

    case (state)
      IDLE: begin
        // addr_ok is gated by resetn so it is low during reset as well.
        if (resetn && data_req) begin
          data_addr_ok    = 1'b1;
          owner_data_next = 1'b1;
          wr_next         = data_wr;
          size_next       = data_size;
          addr_next       = data_addr;
          wdat_next       = data_wdata;
          aw_done_next    = 1'b0;
          w_done_next     = 1'b0;
          state_next      = data_wr ? WR_REQ : RD_ADDR;
        end else if (resetn && inst_req) begin
          inst_addr_ok    = 1'b1;
          owner_data_next = 1'b0;
          wr_next         = 1'b0;
          size_next       = inst_size;
          addr_next       = inst_addr;
          wdat_next       = 32'd0;
          state_next      = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (owner_data) begin
            data_data_ok = 1'b1;
            data_rdata   = rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = rdata;
          end
          state_next = IDLE;
        end
      end
      WR_REQ: begin
        // Address and data channels complete independently.
        awvalid      = !aw_done;
        wvalid       = !w_done;
        aw_done_next = aw_done | awready;
        w_done_next  = w_done | wready;
        if (aw_done_next && w_done_next) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = WR_RESP;
        end
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sraml_axi_bridge.sv
// Directed testbench for sraml_axi_bridge. Inputs change on the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_sraml_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  sraml_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Single comparison point: counts and reports every check.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Simple write with both handshakes in the same cycle.
  task automatic do_write(input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_strb);
    step();
    data_req = 1'b1; data_wr = 1'b1; data_size = sz; data_addr = a; data_wdata = d;
    #1 chk("wr_addr_ok", data_addr_ok, 1);
    step();
    data_req = 1'b0; awready = 1'b1; wready = 1'b1;
    #1 chk("wr_wstrb", wstrb, exp_strb);
    chk("wr_wdata", wdata, d);
    chk("wr_awaddr", awaddr, a);
    chk("wr_awsize", awsize, {1'b0, sz});
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    #1 chk("wr_resp_bready", bready, 1);
    chk("wr_resp_awvalid", awvalid, 0);
    chk("wr_resp_dok", data_data_ok, 1);
    step();
    bvalid = 1'b0;
    #1 chk("wr_idle_dok", data_data_ok, 0);
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 4'hF; rdata = 0; rresp = 2'b10; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 4'hF; bresp = 2'b10; bvalid = 0;

    // Reset state and constant fields
    step(); step();
    #1 chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("const_wlast", wlast, 1);
    chk("const_awid", awid, 1);
    chk("const_wid", wid, 1);
    chk("const_arburst", arburst, 1);
    chk("const_arlen", arlen, 0);
    step();
    resetn = 1'b1;

    // Instruction read at the boot vector
    step();
    inst_req = 1; inst_size = 2; inst_addr = 32'hBFC00000;
    #1 chk("i_addr_ok", inst_addr_ok, 1);
    chk("i_daddr_ok", data_addr_ok, 0);
    step();
    inst_req = 0; arready = 1;
    #1 chk("i_arvalid", arvalid, 1);
    chk("i_araddr", araddr, 32'hBFC00000);
    chk("i_arid", arid, 0);
    chk("i_arsize", arsize, 2);
    step();
    arready = 0;
    #1 chk("i_rready", rready, 1);
    chk("i_arvalid_off", arvalid, 0);
    chk("i_dok_wait", inst_data_ok, 0);
    step();
    rvalid = 1; rdata = 32'h3C080001;
    #1 chk("i_data_ok", inst_data_ok, 1);
    chk("i_rdata", inst_rdata, 32'h3C080001);
    chk("i_ddata_ok", data_data_ok, 0);
    step();
    rvalid = 0;
    #1 chk("i_dok_pulse", inst_data_ok, 0);
    chk("i_rready_off", rready, 0);

    // Simultaneous requests: data wins, inst waits
    inst_req = 1; inst_size = 2; inst_addr = 32'h00001000;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000010;
    #1 chk("arb_daddr_ok", data_addr_ok, 1);
    chk("arb_iaddr_ok", inst_addr_ok, 0);
    step();
    data_req = 0; arready = 1;
    #1 chk("arb_busy_iaddr_ok", inst_addr_ok, 0);
    chk("arb_arid", arid, 1);
    chk("arb_araddr", araddr, 32'h80000010);
    step();
    arready = 0; rvalid = 1; rdata = 32'h12345678;
    #1 chk("arb_ddata_ok", data_data_ok, 1);
    chk("arb_drdata", data_rdata, 32'h12345678);
    chk("arb_idata_ok", inst_data_ok, 0);
    chk("arb_rd_iaddr_ok", inst_addr_ok, 0);
    step();
    rvalid = 0;
    #1 chk("arb_inst_next", inst_addr_ok, 1);
    step();
    inst_req = 0; arready = 1;
    #1 chk("arb2_arid", arid, 0);
    chk("arb2_araddr", araddr, 32'h00001000);
    step();
    arready = 0; rvalid = 1; rdata = 32'hCAFEF00D;
    #1 chk("arb2_idata_ok", inst_data_ok, 1);
    chk("arb2_irdata", inst_rdata, 32'hCAFEF00D);
    step();
    rvalid = 0;

    // Byte write, wready two cycles ahead of awready
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003; data_wdata = 32'h000000AB;
    #1 chk("b_addr_ok", data_addr_ok, 1);
    step();
    data_req = 0; wready = 1;
    #1 chk("b_awvalid", awvalid, 1);
    chk("b_wvalid", wvalid, 1);
    chk("b_wstrb", wstrb, 4'b1000);
    chk("b_wdata", wdata, 32'h000000AB);
    chk("b_awaddr", awaddr, 32'h80000003);
    step();
    wready = 0;
    #1 chk("b_wvalid_drop", wvalid, 0);
    chk("b_awvalid_hold", awvalid, 1);
    step();
    awready = 1;
    #1 chk("b_awvalid_hold2", awvalid, 1);
    chk("b_bready_early", bready, 0);
    step();
    awready = 0;
    #1 chk("b_awvalid_drop", awvalid, 0);
    chk("b_bready", bready, 1);
    chk("b_dok_wait", data_data_ok, 0);
    step();
    bvalid = 1;
    #1 chk("b_dok", data_data_ok, 1);
    step();
    bvalid = 0;
    #1 chk("b_dok_pulse", data_data_ok, 0);
    chk("b_bready_off", bready, 0);

    // Half-word, word and another byte lane
    do_write(2'd1, 32'h80000002, 32'h0000BEEF, 4'b1100);
    do_write(2'd2, 32'h80000004, 32'hDEADBEEF, 4'b1111);
    do_write(2'd0, 32'h80000005, 32'h00000055, 4'b0010);

    // Reset in the middle of a read's data phase
    step();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000020;
    step();
    data_req = 0; arready = 1;
    step();
    arready = 0; inst_req = 1; inst_addr = 32'h00002000;
    #1 chk("mr_rready", rready, 1);
    #2 resetn = 1'b0;
    #1 chk("mr_rst_rready", rready, 0);
    chk("mr_rst_arvalid", arvalid, 0);
    chk("mr_rst_iaddr_ok", inst_addr_ok, 0);
    chk("mr_rst_dok", data_data_ok, 0);
    step();
    inst_req = 0; resetn = 1'b1; rvalid = 1; rdata = 32'h55AA55AA;
    #1 chk("mr_late_dok", data_data_ok, 0);
    chk("mr_late_rready", rready, 0);
    step();
    rvalid = 0;
    #1 chk("mr_idle_arvalid", arvalid, 0);

    // Pending request right at reset release
    resetn = 1'b0;
    inst_req = 1; inst_size = 2; inst_addr = 32'h00003000;
    step();
    resetn = 1'b1;
    #1 chk("rel_iaddr_ok", inst_addr_ok, 1);
    step();
    inst_req = 0;
    #1 chk("rel_arvalid", arvalid, 1);
    chk("rel_araddr", araddr, 32'h00003000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
